ws2812_frame_driver: RTL and testbench



---
 rtl/ws2812_frame_driver_if.sv | 12 +
 rtl/ws2812_frame_driver.sv | 160 ++++++++++++++++
 tb/tb_ws2812_frame_driver.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ws2812_frame_driver_if.sv
// Pixel stream handshake between the frame generator (master) and the
// WS2812 strip driver (slave). pix_ready reflects the driver's holding buffer.
interface ws2812_frame_driver_if #(
    parameter int BITS_PER_LED = 24
);
    logic [BITS_PER_LED-1:0] pix_data;
    logic                    pix_valid;
    logic                    pix_ready;

    modport master (output pix_data, output pix_valid, input  pix_ready);
    modport slave  (input  pix_data, input  pix_valid, output pix_ready);
endinterface

// File: rtl/ws2812_frame_driver.sv
// WS2812 frame driver: streams NUM_LEDS pixels of BITS_PER_LED bits, MSB
// first, onto a one-wire strip with no gaps between bits or pixels, then
// holds the line low for the latch period. A one-entry holding buffer lets
// the next pixel be prefetched while the current one is shifting out.
module ws2812_frame_driver #(
    parameter int BITS_PER_LED = 24,
    parameter int NUM_LEDS     = 8,
    parameter int T0H          = 19,
    parameter int T0L          = 40,
    parameter int T1H          = 38,
    parameter int T1L          = 21,
    parameter int T_RES        = 2880,
    parameter int CW           = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    ws2812_frame_driver_if.slave        pix,
    output logic                        to_light,
    output logic                        busy,
    output logic                        frame_done,
    output logic                        underrun
);

    localparam int BW = (BITS_PER_LED > 1) ? $clog2(BITS_PER_LED) : 1;
    localparam int PW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    localparam logic [CW-1:0] T0H_END   = CW'(T0H - 1);
    localparam logic [CW-1:0] T0L_END   = CW'(T0L - 1);
    localparam logic [CW-1:0] T1H_END   = CW'(T1H - 1);
    localparam logic [CW-1:0] T1L_END   = CW'(T1L - 1);
    localparam logic [CW-1:0] T_RES_END = CW'(T_RES - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(BITS_PER_LED - 1);
    localparam logic [PW-1:0] PIX_LAST  = PW'(NUM_LEDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HIGH,
        ST_LOW,
        ST_LATCH
    } state_t;

    state_t                  state;
    logic [BITS_PER_LED-1:0] buf_data;
    logic                    buf_full;
    logic [BITS_PER_LED-1:0] shreg;
    logic [BW-1:0]           bit_cnt;
    logic [PW-1:0]           pix_cnt;
    logic [CW-1:0]           tcnt;
    logic                    high_end;
    logic                    low_end;

    assign pix.pix_ready = ~buf_full;
    assign busy          = (state != ST_IDLE);

    // The bit currently on the wire is the shift-register MSB; it picks the high/low split.
    assign high_end = shreg[BITS_PER_LED-1] ? (tcnt == T1H_END) : (tcnt == T0H_END);
    assign low_end  = shreg[BITS_PER_LED-1] ? (tcnt == T1L_END) : (tcnt == T0L_END);

    // Frame sequencer, holding buffer and registered line/pulse outputs in one place.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            buf_data   <= '0;
            buf_full   <= 1'b0;
            shreg      <= '0;
            bit_cnt    <= '0;
            pix_cnt    <= '0;
            tcnt       <= '0;
            to_light   <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            underrun   <= 1'b0;

            if (pix.pix_valid && !buf_full) begin
                buf_data <= pix.pix_data;
                buf_full <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_WAIT;
                        tcnt    <= '0;
                        pix_cnt <= '0;
                    end
                end

                ST_WAIT: begin
                    if (buf_full) begin
                        shreg    <= buf_data;
                        buf_full <= 1'b0;
                        bit_cnt  <= '0;
                        tcnt     <= '0;
                        to_light <= 1'b1;
                        state    <= ST_HIGH;
                    end
                end

                ST_HIGH: begin
                    if (high_end) begin
                        tcnt     <= '0;
                        to_light <= 1'b0;
                        state    <= ST_LOW;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end

                ST_LOW: begin
                    if (low_end) begin
                        tcnt <= '0;
                        if (bit_cnt != BIT_LAST) begin
                            shreg    <= shreg << 1;
                            bit_cnt  <= bit_cnt + 1'b1;
                            to_light <= 1'b1;
                            state    <= ST_HIGH;
                        end else if (pix_cnt != PIX_LAST) begin
                            if (buf_full) begin
                                shreg    <= buf_data;
                                buf_full <= 1'b0;
                                bit_cnt  <= '0;
                                pix_cnt  <= pix_cnt + 1'b1;
                                to_light <= 1'b1;
                                state    <= ST_HIGH;
                            end else begin
                                underrun <= 1'b1;
                                state    <= ST_LATCH;
                            end
                        end else begin
                            state <= ST_LATCH;
                        end
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end

                ST_LATCH: begin
                    if (tcnt == T_RES_END) begin
                        tcnt       <= '0;
                        frame_done <= 1'b1;
                        state      <= ST_IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end

                default: begin
                    tcnt     <= '0;
                    to_light <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_frame_driver.sv
// Directed bench for ws2812_frame_driver: a GRB instance (2 pixels per frame)
// and a GRBW instance (1 pixel per frame), both with short bit timings.
module tb_ws2812_frame_driver;

    logic clk;
    logic rst;
    logic start;
    logic start2;
    logic to_light, busy, frame_done, underrun;
    logic to_light2, busy2, frame_done2, underrun2;

    int n_checks;
    int n_errors;

    logic [23:0] feed_q[$];
    logic        cap;

    logic tl_log [1024];
    logic fd_log [1024];
    logic ur_log [1024];
    logic bz_log [1024];
    logic rd_log [1024];

    ws2812_frame_driver_if #(.BITS_PER_LED(24)) pif ();
    ws2812_frame_driver_if #(.BITS_PER_LED(32)) pif2 ();

    ws2812_frame_driver #(
        .BITS_PER_LED(24), .NUM_LEDS(2), .T0H(2), .T0L(4), .T1H(4), .T1L(2),
        .T_RES(10), .CW(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pix(pif),
        .to_light(to_light), .busy(busy), .frame_done(frame_done), .underrun(underrun)
    );

    ws2812_frame_driver #(
        .BITS_PER_LED(32), .NUM_LEDS(1), .T0H(2), .T0L(4), .T1H(4), .T1L(2),
        .T_RES(10), .CW(16)
    ) dut2 (
        .clk(clk), .rst(rst), .start(start2), .pix(pif2),
        .to_light(to_light2), .busy(busy2), .frame_done(frame_done2), .underrun(underrun2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pixel source for the GRB instance: offers the queue head, pops it once accepted.
    initial begin
        pif.pix_valid = 1'b0;
        pif.pix_data  = '0;
        cap           = 1'b0;
        forever begin
            @(negedge clk);
            if (cap && feed_q.size() > 0) void'(feed_q.pop_front());
            if (feed_q.size() > 0) begin
                pif.pix_valid = 1'b1;
                pif.pix_data  = feed_q[0];
            end else begin
                pif.pix_valid = 1'b0;
            end
            cap = pif.pix_valid && pif.pix_ready;
        end
    end

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b0;
        start = 1'b0;
        start2 = 1'b0;
        pif2.pix_valid = 1'b0;
        feed_q.delete();
        cap = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #2;
    endtask

    task automatic watch(input bit sel, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tl_log[i] = sel ? to_light2   : to_light;
            fd_log[i] = sel ? frame_done2 : frame_done;
            ur_log[i] = sel ? underrun2   : underrun;
            bz_log[i] = sel ? busy2       : busy;
            rd_log[i] = sel ? pif2.pix_ready : pif.pix_ready;
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        n_checks++; if (to_light !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_to_light: got %b expected 0", to_light); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (frame_done !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_frame_done: got %b expected 0", frame_done); end
        n_checks++; if (underrun !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_underrun: got %b expected 0", underrun); end
        n_checks++; if (pif.pix_ready !== 1'b1) begin n_errors++; $display("[TB] FAIL reset_pix_ready: got %b expected 1", pif.pix_ready); end
        n_checks++; if (to_light2 !== 1'b0 || busy2 !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_rgbw: got to_light=%b busy=%b expected 0 0", to_light2, busy2); end
        n_checks++; if (pif2.pix_ready !== 1'b1) begin n_errors++; $display("[TB] FAIL reset_rgbw_ready: got %b expected 1", pif2.pix_ready); end
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_idle_after_release: busy got %b expected 0", busy); end
    endtask

    task automatic test_prefetch();
        logic [47:0] bits;
        logic [5:0]  obs, expv;
        int cnt;
        do_reset();
        feed_q.push_back(24'hFF0000);
        feed_q.push_back(24'h00000F);
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++; if (to_light !== 1'b0 || busy !== 1'b1) begin n_errors++; $display("[TB] FAIL prefetch_wait: got to_light=%b busy=%b expected 0 1", to_light, busy); end
        watch(1'b0, 300);
        bits = {24'hFF0000, 24'h00000F};
        for (int i = 0; i < 48; i++) begin
            for (int j = 0; j < 6; j++) obs[5-j] = tl_log[6*i+j];
            expv = bits[47-i] ? 6'b111100 : 6'b110000;
            n_checks++; if (obs !== expv) begin n_errors++; $display("[TB] FAIL prefetch_bit%0d: got %b expected %b", i, obs, expv); end
        end
        cnt = 0;
        for (int i = 288; i < 298; i++) if (tl_log[i] !== 1'b0 || bz_log[i] !== 1'b1) cnt++;
        n_checks++; if (cnt !== 0) begin n_errors++; $display("[TB] FAIL prefetch_latch: got %0d bad latch cycles expected 0", cnt); end
        n_checks++; if (fd_log[298] !== 1'b1 || fd_log[299] !== 1'b0) begin n_errors++; $display("[TB] FAIL prefetch_frame_done: got %b%b expected 10", fd_log[298], fd_log[299]); end
        n_checks++; if (bz_log[298] !== 1'b0) begin n_errors++; $display("[TB] FAIL prefetch_busy_fall: got %b expected 0", bz_log[298]); end
        cnt = 0;
        for (int i = 0; i < 300; i++) if (ur_log[i] !== 1'b0) cnt++;
        n_checks++; if (cnt !== 0) begin n_errors++; $display("[TB] FAIL prefetch_underrun: got %0d pulses expected 0", cnt); end
        cnt = 0;
        for (int i = 0; i < 300; i++) if (fd_log[i] === 1'b1) cnt++;
        n_checks++; if (cnt !== 1) begin n_errors++; $display("[TB] FAIL prefetch_done_count: got %0d expected 1", cnt); end
    endtask

    task automatic test_underrun();
        logic [5:0] obs, expv;
        logic [23:0] pixv;
        int cnt;
        do_reset();
        feed_q.push_back(24'hAAAAAA);
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        watch(1'b0, 170);
        pixv = 24'hAAAAAA;
        for (int i = 0; i < 24; i++) begin
            for (int j = 0; j < 6; j++) obs[5-j] = tl_log[6*i+j];
            expv = pixv[23-i] ? 6'b111100 : 6'b110000;
            n_checks++; if (obs !== expv) begin n_errors++; $display("[TB] FAIL underrun_bit%0d: got %b expected %b", i, obs, expv); end
        end
        n_checks++; if (ur_log[143] !== 1'b0 || ur_log[144] !== 1'b1 || ur_log[145] !== 1'b0) begin n_errors++; $display("[TB] FAIL underrun_pulse: got %b%b%b expected 010", ur_log[143], ur_log[144], ur_log[145]); end
        cnt = 0;
        for (int i = 144; i < 170; i++) if (tl_log[i] !== 1'b0) cnt++;
        n_checks++; if (cnt !== 0) begin n_errors++; $display("[TB] FAIL underrun_no_second_pixel: got %0d high cycles expected 0", cnt); end
        n_checks++; if (fd_log[153] !== 1'b0 || fd_log[154] !== 1'b1) begin n_errors++; $display("[TB] FAIL underrun_frame_done: got %b%b expected 01", fd_log[153], fd_log[154]); end
    endtask

    task automatic test_async_reset();
        logic [23:0] w0, w1;
        int cnt;
        do_reset();
        feed_q.push_back(24'hFFFFFF);
        feed_q.push_back(24'h00FF00);
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (33) @(negedge clk);
        n_checks++; if (to_light !== 1'b1 || pif.pix_ready !== 1'b0) begin n_errors++; $display("[TB] FAIL areset_pre: got to_light=%b ready=%b expected 1 0", to_light, pif.pix_ready); end
        #1 rst = 1'b0;
        #1;
        n_checks++; if (to_light !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("[TB] FAIL areset_immediate: got to_light=%b busy=%b expected 0 0", to_light, busy); end
        n_checks++; if (pif.pix_ready !== 1'b1) begin n_errors++; $display("[TB] FAIL areset_buffer: got ready=%b expected 1", pif.pix_ready); end
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        watch(1'b0, 300);
        cnt = 0;
        for (int i = 0; i < 300; i++) if (fd_log[i] !== 1'b0 || tl_log[i] !== 1'b0 || bz_log[i] !== 1'b0) cnt++;
        n_checks++; if (cnt !== 0) begin n_errors++; $display("[TB] FAIL areset_lost_frame: got %0d active cycles expected 0", cnt); end
        @(posedge clk); #2;
        feed_q.push_back(24'h123456);
        feed_q.push_back(24'hABCDEF);
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        watch(1'b0, 300);
        for (int i = 0; i < 24; i++) begin
            w0[23-i] = tl_log[6*i+2];
            w1[23-i] = tl_log[144+6*i+2];
        end
        n_checks++; if (w0 !== 24'h123456 || w1 !== 24'hABCDEF) begin n_errors++; $display("[TB] FAIL areset_clean_frame: got %h %h expected 123456 abcdef", w0, w1); end
        cnt = 0;
        for (int i = 0; i < 300; i++) if (ur_log[i] !== 1'b0) cnt++;
        n_checks++; if (cnt !== 0 || fd_log[298] !== 1'b1) begin n_errors++; $display("[TB] FAIL areset_clean_end: got underruns=%0d done=%b expected 0 1", cnt, fd_log[298]); end
    endtask

    task automatic test_late_pixel();
        int cnt;
        do_reset();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        watch(1'b0, 20);
        cnt = 0;
        for (int i = 0; i < 20; i++) if (tl_log[i] !== 1'b0 || bz_log[i] !== 1'b1) cnt++;
        n_checks++; if (cnt !== 0) begin n_errors++; $display("[TB] FAIL late_wait_hold: got %0d bad cycles expected 0", cnt); end
        #2;
        feed_q.push_back(24'h000000);
        feed_q.push_back(24'hFFFFFF);
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (to_light !== 1'b0 || busy !== 1'b1) begin n_errors++; $display("[TB] FAIL late_after_capture: got to_light=%b busy=%b expected 0 1", to_light, busy); end
        @(negedge clk);
        n_checks++; if (to_light !== 1'b1) begin n_errors++; $display("[TB] FAIL late_high_start: got %b expected 1", to_light); end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        watch(1'b0, 320);
        cnt = 0;
        for (int i = 0; i < 320; i++) if (fd_log[i] === 1'b1) cnt++;
        n_checks++; if (cnt !== 1 || fd_log[296] !== 1'b1) begin n_errors++; $display("[TB] FAIL late_single_done: got count=%0d at296=%b expected 1 1", cnt, fd_log[296]); end
        n_checks++; if (bz_log[319] !== 1'b0) begin n_errors++; $display("[TB] FAIL late_restart_ignored: got busy=%b expected 0", bz_log[319]); end
    endtask

    task automatic test_back_to_back();
        logic [23:0] w0, w1;
        do_reset();
        feed_q.push_back(24'hC3A50F);
        feed_q.push_back(24'h5A5A5A);
        feed_q.push_back(24'h81FF18);
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++; if (pif.pix_ready !== 1'b0) begin n_errors++; $display("[TB] FAIL bp_full_wait: got ready=%b expected 0", pif.pix_ready); end
        watch(1'b0, 300);
        n_checks++; if (rd_log[0] !== 1'b1 || rd_log[1] !== 1'b0) begin n_errors++; $display("[TB] FAIL bp_ready_load1: got %b%b expected 10", rd_log[0], rd_log[1]); end
        n_checks++; if (rd_log[143] !== 1'b0 || rd_log[144] !== 1'b1 || rd_log[145] !== 1'b0) begin n_errors++; $display("[TB] FAIL bp_ready_load2: got %b%b%b expected 010", rd_log[143], rd_log[144], rd_log[145]); end
        for (int i = 0; i < 24; i++) begin
            w0[23-i] = tl_log[6*i+2];
            w1[23-i] = tl_log[144+6*i+2];
        end
        n_checks++; if (w0 !== 24'hC3A50F || w1 !== 24'h5A5A5A) begin n_errors++; $display("[TB] FAIL bp_frame1_pixels: got %h %h expected c3a50f 5a5a5a", w0, w1); end
        n_checks++; if (fd_log[298] !== 1'b1 || rd_log[299] !== 1'b0) begin n_errors++; $display("[TB] FAIL bp_third_held: got done=%b ready=%b expected 1 0", fd_log[298], rd_log[299]); end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        watch(1'b0, 160);
        for (int i = 0; i < 24; i++) w0[23-i] = tl_log[6*i+2];
        n_checks++; if (w0 !== 24'h81FF18) begin n_errors++; $display("[TB] FAIL bp_frame2_pixel: got %h expected 81ff18", w0); end
        n_checks++; if (ur_log[144] !== 1'b1 || fd_log[154] !== 1'b1 || rd_log[159] !== 1'b1) begin n_errors++; $display("[TB] FAIL bp_frame2_end: got ur=%b done=%b ready=%b expected 1 1 1", ur_log[144], fd_log[154], rd_log[159]); end
    endtask

    task automatic test_rgbw();
        logic [31:0] pixv;
        logic [5:0]  obs, expv;
        int cnt;
        do_reset();
        pixv = 32'h80000001;
        @(negedge clk);
        pif2.pix_valid = 1'b1;
        pif2.pix_data  = pixv;
        @(negedge clk);
        pif2.pix_valid = 1'b0;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        watch(1'b1, 210);
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 6; j++) obs[5-j] = tl_log[6*i+j];
            expv = pixv[31-i] ? 6'b111100 : 6'b110000;
            n_checks++; if (obs !== expv) begin n_errors++; $display("[TB] FAIL rgbw_bit%0d: got %b expected %b", i, obs, expv); end
        end
        cnt = 0;
        for (int i = 0; i < 210; i++) if (fd_log[i] === 1'b1 || ur_log[i] === 1'b1) cnt++;
        n_checks++; if (fd_log[202] !== 1'b1 || fd_log[201] !== 1'b0 || cnt !== 1) begin n_errors++; $display("[TB] FAIL rgbw_frame_done: got at202=%b pulses=%0d expected 1 1", fd_log[202], cnt); end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        start2 = 1'b0;
        pif2.pix_valid = 1'b0;
        pif2.pix_data = '0;
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_prefetch();
        test_underrun();
        test_async_reset();
        test_late_pixel();
        test_back_to_back();
        test_rgbw();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
